// File: rtl/inst_sram_like_slave.sv
// rtl/inst_sram_like_slave.sv - sram-like memory responder with in-order fixed-latency response queue
module inst_sram_like_slave #(
   parameter int MEM_AW    = 12,
   parameter int LATENCY   = 2,
   parameter int DEPTH     = 2,
   parameter     INIT_FILE = ""
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req,
   input  logic        wr,
   input  logic [1:0]  size,
   input  logic [31:0] addr,
   input  logic [3:0]  wstrb,
   input  logic [31:0] wdata,
   output logic        addr_ok,
   output logic        data_ok,
   output logic [31:0] rdata
);

   localparam int         PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [2:0] CNT_INIT = 3'(LATENCY - 1);
   localparam logic [2:0] OCC_MAX  = 3'(DEPTH);

   // Word array; contents survive reset so a reset does not wipe the program image.
   logic [31:0] mem_q [0:(1<<MEM_AW)-1];

   // Response queue storage and bookkeeping.
   logic [31:0]   rdata_q [DEPTH];
   logic [31:0]   rdata_d [DEPTH];
   logic [2:0]    cnt_q   [DEPTH];
   logic [2:0]    cnt_d   [DEPTH];
   logic [DEPTH-1:0] valid_q, valid_d;
   logic [PW-1:0] head_q, head_d;
   logic [PW-1:0] tail_q, tail_d;
   logic [2:0]    occ_q, occ_d;

   logic [MEM_AW-1:0] idx;
   logic [31:0]       rd_word;
   logic [31:0]       mem_wdata_d;
   logic              push;
   logic              pop;
   logic              unused_bits;

   assign idx         = addr[MEM_AW+1:2];
   assign rd_word     = mem_q[idx];
   assign unused_bits = ^{size, addr[31:MEM_AW+2], addr[1:0]};

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      if (p == PW'(DEPTH - 1)) return '0;
      return p + PW'(1);
   endfunction

   // Handshake outputs: head response matures when its countdown hits zero; a pop frees a slot for a same-cycle push.
   always_comb begin
      pop     = (occ_q != 3'd0) && (cnt_q[head_q] == 3'd0);
      data_ok = pop;
      rdata   = pop ? rdata_q[head_q] : 32'd0;
      addr_ok = rst_n && req && ((occ_q < OCC_MAX) || pop);
      push    = addr_ok;
   end

   // Byte-lane merge of write data into the addressed word.
   always_comb begin
      mem_wdata_d = rd_word;
      for (int b = 0; b < 4; b++) begin
         if (wstrb[b]) mem_wdata_d[8*b +: 8] = wdata[8*b +: 8];
      end
   end

   // Memory write port; reads are sampled into the queue at the same edge.
   always_ff @(posedge clk) begin
      if (push && wr) mem_q[idx] <= mem_wdata_d;
   end

   // Queue next state: age occupied entries, retire the head, append the new response.
   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         rdata_d[i] = rdata_q[i];
         cnt_d[i]   = (valid_q[i] && (cnt_q[i] != 3'd0)) ? cnt_q[i] - 3'd1 : cnt_q[i];
      end
      valid_d = valid_q;
      head_d  = head_q;
      tail_d  = tail_q;
      if (pop) begin
         valid_d[head_q] = 1'b0;
         head_d          = ptr_inc(head_q);
      end
      if (push) begin
         valid_d[tail_q] = 1'b1;
         cnt_d[tail_q]   = CNT_INIT;
         rdata_d[tail_q] = wr ? 32'd0 : rd_word;
         tail_d          = ptr_inc(tail_q);
      end
      occ_d = occ_q + {2'b00, push} - {2'b00, pop};
   end

   // Queue state register; reset drops every outstanding response.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            rdata_q[i] <= '0;
            cnt_q[i]   <= '0;
         end
         valid_q <= '0;
         head_q  <= '0;
         tail_q  <= '0;
         occ_q   <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            rdata_q[i] <= rdata_d[i];
            cnt_q[i]   <= cnt_d[i];
         end
         valid_q <= valid_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         occ_q   <= occ_d;
      end
   end

endmodule
